// File: rtl/sipo_deser_if.sv
// Serial bit stream in, word handshake out, overrun status and clear.
// The master drives the bit stream and consumes words; the deserializer is the slave.
interface sipo_deser_if #(
   parameter int WIDTH = 4
);
   logic             serial_in;
   logic             bit_valid;
   logic             frame_start;
   logic [WIDTH-1:0] word_out;
   logic             word_valid;
   logic             word_ready;
   logic             busy;
   logic             overrun;
   logic             overrun_clr;

   modport master (
      output serial_in, bit_valid, frame_start, word_ready, overrun_clr,
      input  word_out, word_valid, busy, overrun
   );

   modport slave (
      input  serial_in, bit_valid, frame_start, word_ready, overrun_clr,
      output word_out, word_valid, busy, overrun
   );
endinterface

// File: rtl/sipo_deser.sv
// LSB-first serial-to-parallel deserializer with framed input, a one-word
// holding register on a valid/ready handshake, and a sticky overrun flag.
module sipo_deser #(
   parameter int WIDTH = 4
) (
   input  logic         clk,
   input  logic         reset,
   sipo_deser_if.slave  bus
);
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t           state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] sh;
   logic [WIDTH-1:0] word_q;
   logic             valid_q;
   logic             busy_q;
   logic             overrun_q;

   logic [WIDTH-1:0] sh_next;
   logic             complete;
   logic             consume;

   always_comb begin
      sh_next  = {bus.serial_in, sh[WIDTH-1:1]};
      // A frame_start bit is always bit 0, so it can never complete a word.
      complete = bus.bit_valid && !bus.frame_start && (state == SHIFT) &&
                 (cnt == CW'(WIDTH - 1));
      consume  = valid_q && bus.word_ready;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         sh        <= '0;
         word_q    <= '0;
         valid_q   <= 1'b0;
         busy_q    <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         if (bus.bit_valid && bus.frame_start) begin
            sh     <= sh_next;
            cnt    <= CW'(1);
            state  <= SHIFT;
            busy_q <= 1'b1;
         end else if (bus.bit_valid && state == SHIFT) begin
            sh <= sh_next;
            if (complete) begin
               cnt    <= '0;
               state  <= IDLE;
               busy_q <= 1'b0;
            end else begin
               cnt <= cnt + CW'(1);
            end
         end

         // Clear first so that a same-edge overrun set takes priority.
         if (bus.overrun_clr)
            overrun_q <= 1'b0;

         if (complete) begin
            if (!valid_q || bus.word_ready) begin
               word_q  <= sh_next;
               valid_q <= 1'b1;
            end else begin
               overrun_q <= 1'b1;
            end
         end else if (consume) begin
            valid_q <= 1'b0;
         end
      end
   end

   assign bus.word_out   = word_q;
   assign bus.word_valid = valid_q;
   assign bus.busy       = busy_q;
   assign bus.overrun    = overrun_q;
endmodule

// File: tb/tb_sipo_deser.sv
// Directed bench for sipo_deser with hand-computed expected words.
module tb_sipo_deser;
   logic clk = 1'b0;
   logic reset;
   int   total = 0;
   int   bad   = 0;

   sipo_deser_if #(.WIDTH(4)) bus ();

   sipo_deser #(.WIDTH(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // One clock with the given bit inputs; outputs are stable #1 after the edge.
   task automatic step(input logic v, input logic b, input logic fs);
      bus.bit_valid   = v;
      bus.serial_in   = b;
      bus.frame_start = fs;
      @(posedge clk);
      #1;
      bus.bit_valid   = 1'b0;
      bus.serial_in   = 1'b0;
      bus.frame_start = 1'b0;
   endtask

   // Send a 4-bit word LSB first, frame_start on bit 0.
   task automatic frame(input logic [3:0] w);
      for (int unsigned i = 0; i < 4; i++)
         step(1'b1, w[i], i == 0);
   endtask

   initial begin
      bus.serial_in   = 1'b0;
      bus.bit_valid   = 1'b0;
      bus.frame_start = 1'b0;
      bus.word_ready  = 1'b0;
      bus.overrun_clr = 1'b0;
      reset = 1'b1;
      #12;
      chk("rst_word",    bus.word_out,   4'h0);
      chk("rst_valid",   bus.word_valid, 0);
      chk("rst_busy",    bus.busy,       0);
      chk("rst_overrun", bus.overrun,    0);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;

      // Basic frame: bits 0,1,0,1 -> 1010
      step(1, 0, 1);
      chk("t1_busy_b0", bus.busy, 1);
      step(1, 1, 0);
      step(1, 0, 0);
      chk("t1_valid_b2", bus.word_valid, 0);
      step(1, 1, 0);
      chk("t1_word",  bus.word_out,   4'b1010);
      chk("t1_valid", bus.word_valid, 1);
      chk("t1_busy",  bus.busy,       0);
      bus.word_ready = 1'b1;
      step(0, 0, 0);
      bus.word_ready = 1'b0;
      chk("t1_consumed", bus.word_valid, 0);

      // Gap of 3 cycles between bits 2 and 3
      step(1, 0, 1);
      step(1, 1, 0);
      for (int unsigned i = 0; i < 3; i++) begin
         step(0, 1, 1);
         chk("t2_gap_busy", bus.busy, 1);
      end
      chk("t2_gap_valid", bus.word_valid, 0);
      step(1, 0, 0);
      step(1, 1, 0);
      chk("t2_word",  bus.word_out,   4'b1010);
      chk("t2_valid", bus.word_valid, 1);
      bus.word_ready = 1'b1;
      step(0, 0, 0);
      bus.word_ready = 1'b0;

      // Restart: partial 1,1 abandoned, new frame 1,0,0,0 -> 0001
      step(1, 1, 1);
      step(1, 1, 0);
      frame(4'b0001);
      chk("t3_word",    bus.word_out,   4'b0001);
      chk("t3_valid",   bus.word_valid, 1);
      chk("t3_overrun", bus.overrun,    0);
      bus.word_ready = 1'b1;
      step(0, 0, 0);
      bus.word_ready = 1'b0;

      // Overrun: 1010 held, 0110 dropped
      frame(4'b1010);
      frame(4'b0110);
      chk("t4_word",    bus.word_out,   4'b1010);
      chk("t4_valid",   bus.word_valid, 1);
      chk("t4_overrun", bus.overrun,    1);
      bus.word_ready = 1'b1;
      step(0, 0, 0);
      bus.word_ready = 1'b0;
      chk("t4_consumed",   bus.word_valid, 0);
      chk("t4_ovr_sticky", bus.overrun,    1);
      bus.overrun_clr = 1'b1;
      step(0, 0, 0);
      bus.overrun_clr = 1'b0;
      chk("t4_ovr_clr", bus.overrun, 0);

      // Back-to-back frames, ready held high
      bus.word_ready = 1'b1;
      frame(4'b0011);
      chk("t5_word0",  bus.word_out,   4'b0011);
      chk("t5_valid0", bus.word_valid, 1);
      frame(4'b1100);
      chk("t5_word1",  bus.word_out,   4'b1100);
      chk("t5_valid1", bus.word_valid, 1);
      chk("t5_overrun", bus.overrun,   0);
      step(0, 0, 0);
      bus.word_ready = 1'b0;
      chk("t5_drained", bus.word_valid, 0);

      // Consume and complete on the same edge: new word loaded, no overrun
      frame(4'b0101);
      step(1, 1, 1);
      step(1, 0, 0);
      step(1, 0, 0);
      bus.word_ready = 1'b1;
      step(1, 1, 0);
      bus.word_ready = 1'b0;
      chk("t6_word",    bus.word_out,   4'b1001);
      chk("t6_valid",   bus.word_valid, 1);
      chk("t6_overrun", bus.overrun,    0);

      // Overrun set and clear on the same edge: set wins
      step(1, 0, 1);
      step(1, 0, 0);
      step(1, 0, 0);
      bus.overrun_clr = 1'b1;
      step(1, 0, 0);
      bus.overrun_clr = 1'b0;
      chk("t7_set_wins", bus.overrun,  1);
      chk("t7_word",     bus.word_out, 4'b1001);

      // Reset mid-frame while a word is held
      step(1, 1, 1);
      step(1, 1, 0);
      chk("t8_pre_busy", bus.busy, 1);
      #2;
      reset = 1'b1;
      #1;
      chk("t8_rst_busy",    bus.busy,       0);
      chk("t8_rst_valid",   bus.word_valid, 0);
      chk("t8_rst_word",    bus.word_out,   4'h0);
      chk("t8_rst_overrun", bus.overrun,    0);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      frame(4'b1111);
      chk("t8_word",  bus.word_out,   4'b1111);
      chk("t8_valid", bus.word_valid, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end
endmodule
